// File: rtl/shift_sequencer.sv
// shift_sequencer: feeds a 4-bit shift register (select/data_in), accepts word_in over word_valid/word_ready, streams reg_q[0] LSB-first on tx_bit/tx_valid/tx_ready/tx_last, with GAP_CYCLES idle cycles between words
module shift_sequencer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  output logic [1:0] select,
  output logic [3:0] data_in,
  input  logic [3:0] reg_q,
  output logic       tx_bit,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic accept, bit_done, gap_done, unused_q;
  assign accept   = word_valid && word_ready;
  assign bit_done = state == SHIFT && tx_ready;
  assign gap_done = gap_cnt == 4'(GAP_CYCLES - 1);
  assign tx_bit   = reg_q[0];
  assign unused_q = ^reg_q[3:1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      data_in <= '0;
    end else begin
      state   <= state_nx;
      data_in <= accept ? word_in : data_in;
      bit_cnt <= state == LOAD ? 2'd0 : bit_done ? bit_cnt + 2'd1 : bit_cnt;
      gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LOAD : IDLE;
      LOAD:    state_nx = SHIFT;
      SHIFT:   state_nx = (bit_done && bit_cnt == 2'd3) ? (GAP_CYCLES == 0 ? IDLE : GAP) : SHIFT;
      default: state_nx = gap_done ? IDLE : GAP;
    endcase
  end
  always_comb begin
    word_ready = state == IDLE;
    tx_valid   = state == SHIFT;
    tx_last    = state == SHIFT && bit_cnt == 2'd3;
    select     = state == LOAD ? 2'b10 : bit_done ? 2'b01 : 2'b00;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: checks two sequencers (GAP_CYCLES 0 and 1) each driving a modelled shift register
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] word_in [2];
  logic [1:0] word_valid, word_ready, tx_bit, tx_valid, tx_ready, tx_last;
  logic [1:0] sel [2];
  logic [3:0] din [2];
  logic [3:0] reg_q [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_ok = 0;
  bit [1:0] m_pend, m_loaded;
  int m_sent [2];
  int m_gap [2];
  logic [3:0] m_word [2];
  bit s0 [$];
  bit s1 [$];
  int acc0 [$];
  logic er, ev;
  logic [1:0] es;

  always #5 clk = ~clk;

  shift_sequencer #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .word_in(word_in[0]), .word_valid(word_valid[0]),
    .word_ready(word_ready[0]), .select(sel[0]), .data_in(din[0]), .reg_q(reg_q[0]),
    .tx_bit(tx_bit[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_last(tx_last[0])
  );
  shift_sequencer #(.GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .word_in(word_in[1]), .word_valid(word_valid[1]),
    .word_ready(word_ready[1]), .select(sel[1]), .data_in(din[1]), .reg_q(reg_q[1]),
    .tx_bit(tx_bit[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_last(tx_last[1])
  );

  // the external universal shift register (no reset)
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      reg_q[k] <= sel[k] == 2'b10 ? din[k] : sel[k] == 2'b01 ? {1'b0, reg_q[k][3:1]} : reg_q[k];

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pack(input bit q[$]);
    logic [7:0] v = '0;
    for (int i = 0; i < q.size() && i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  // protocol-level model: word in flight, bits delivered, idle cycles still owed
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      er = !m_pend[k] && m_gap[k] == 0;
      ev = m_pend[k] && m_loaded[k];
      if (!rst && tx_valid[k] && tx_ready[k]) begin
        if (k == 0) s0.push_back(tx_bit[0]);
        else s1.push_back(tx_bit[1]);
      end
      if (rst) begin
        m_pend[k] = 0; m_loaded[k] = 0; m_sent[k] = 0; m_gap[k] = 0; m_word[k] = '0;
      end else if (er && word_valid[k]) begin
        m_pend[k] = 1; m_loaded[k] = 0; m_sent[k] = 0; m_word[k] = word_in[k];
        if (k == 0) acc0.push_back(cyc);
      end else if (m_pend[k] && !m_loaded[k]) begin
        m_loaded[k] = 1;
      end else if (ev && tx_ready[k]) begin
        m_sent[k]++;
        if (m_sent[k] == 4) begin
          m_pend[k] = 0;
          m_gap[k] = k;
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end
    end
    if (rst) m_ok = 1;
  end

  always @(negedge clk)
    if (m_ok)
      for (int k = 0; k < 2; k++) begin
        ev = m_pend[k] && m_loaded[k];
        er = !m_pend[k] && m_gap[k] == 0;
        es = (m_pend[k] && !m_loaded[k]) ? 2'b10 : (ev && tx_ready[k]) ? 2'b01 : 2'b00;
        chk("word_ready", k, 8'(word_ready[k]), 8'(er));
        chk("tx_valid", k, 8'(tx_valid[k]), 8'(ev));
        chk("select", k, 8'(sel[k]), 8'(es));
        chk("data_in", k, 8'(din[k]), 8'(m_word[k]));
        chk("tx_last", k, 8'(tx_last[k]), 8'(ev && m_sent[k] == 3));
        if (ev) chk("tx_bit", k, 8'(tx_bit[k]), 8'(m_word[k][m_sent[k]]));
      end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!word_ready[k] && n < 30) begin
      tick;
      n++;
    end
    chk("idle_timeout", k, 8'(word_ready[k]), 8'd1);
  endtask

  initial begin
    word_in[0] = '0; word_in[1] = '0;
    word_valid = '0;
    tx_ready = 2'b11;
    tick;
    tick;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 1, 8'(word_ready[1]), 8'd1);
    chk("rst_select", 1, 8'(sel[1]), 8'd0);
    chk("rst_data_in", 1, 8'(din[1]), 8'd0);
    chk("rst_tx_valid", 1, 8'(tx_valid[1]), 8'd0);
    chk("rst_tx_last", 1, 8'(tx_last[1]), 8'd0);
    // word 1011, no backpressure
    word_in[1] = 4'b1011; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    @(negedge clk);
    chk("t1_load_sel", 1, 8'(sel[1]), 8'h2);
    chk("t1_load_din", 1, 8'(din[1]), 8'hb);
    tick;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_sel", 1, 8'(sel[1]), 8'h1);
      chk("t1_bit", 1, 8'(tx_bit[1]), 8'(i == 2 ? 0 : 1));
      chk("t1_last", 1, 8'(tx_last[1]), 8'(i == 3));
      tick;
    end
    @(negedge clk);
    chk("t1_gap_ready", 1, 8'(word_ready[1]), 8'd0);
    chk("t1_gap_valid", 1, 8'(tx_valid[1]), 8'd0);
    tick;
    @(negedge clk);
    chk("t1_ready_back", 1, 8'(word_ready[1]), 8'd1);
    chk("t1_stream", 1, pack(s1), 8'h0b);
    // word 0110, stalled 3 cycles on bit 1
    s1.delete();
    word_in[1] = 4'b0110; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    tick;
    tick;
    tx_ready[1] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_sel", 1, 8'(sel[1]), 8'd0);
      chk("t2_stall_bit", 1, 8'(tx_bit[1]), 8'd1);
      tick;
    end
    tx_ready[1] = 1;
    wait_idle(1);
    chk("t2_len", 1, 8'(s1.size()), 8'd4);
    chk("t2_stream", 1, pack(s1), 8'h06);
    // word_valid pulsed during SHIFT of 1100
    s1.delete();
    word_in[1] = 4'b1100; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    tick;
    word_in[1] = 4'b0101; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    @(negedge clk);
    chk("t4_din_kept", 1, 8'(din[1]), 8'h0c);
    wait_idle(1);
    chk("t4_len", 1, 8'(s1.size()), 8'd4);
    chk("t4_stream", 1, pack(s1), 8'h0c);
    // reset during bit 2 of 1010
    s1.delete();
    word_in[1] = 4'b1010; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    tick;
    tick;
    tick;
    rst = 1; tx_ready[1] = 0;
    tick;
    rst = 0; tx_ready[1] = 1;
    @(negedge clk);
    chk("t5_valid", 1, 8'(tx_valid[1]), 8'd0);
    chk("t5_select", 1, 8'(sel[1]), 8'd0);
    chk("t5_ready", 1, 8'(word_ready[1]), 8'd1);
    chk("t5_din", 1, 8'(din[1]), 8'd0);
    chk("t5_partial", 1, pack(s1), 8'h02);
    s1.delete();
    word_in[1] = 4'b0011; word_valid[1] = 1;
    tick;
    word_valid[1] = 0;
    wait_idle(1);
    chk("t5_len", 1, 8'(s1.size()), 8'd4);
    chk("t5_stream", 1, pack(s1), 8'h03);
    // GAP_CYCLES = 0, back-to-back 1111 then 0001
    s0.delete();
    acc0.delete();
    word_in[0] = 4'b1111; word_valid[0] = 1;
    tick;
    word_in[0] = 4'b0001;
    repeat (6) tick;
    word_valid[0] = 0;
    wait_idle(0);
    chk("t3_accepts", 0, 8'(acc0.size()), 8'd2);
    if (acc0.size() == 2) chk("t3_period", 0, 8'(acc0[1] - acc0[0]), 8'd6);
    chk("t3_len", 0, 8'(s0.size()), 8'd8);
    chk("t3_stream", 0, pack(s0), 8'h1f);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
